// File: rtl/ras_ctrl_pkg.sv
// Shared types for the RAS speculation controller: FSM states, journal entry layout,
// and a saturating counter helper for the optional statistics.
package ras_ctrl_pkg;

    localparam int RAS_ADDR_W = 32;

    typedef enum logic [1:0] {IDLE, COROUT, UNWIND} state_t;

    typedef enum logic {JNL_PUSH, JNL_POP} jnl_op_t;

    typedef struct packed {
        jnl_op_t                 op;
        logic [RAS_ADDR_W-1:0]   addr;
    } jnl_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/ras_ctrl_journal.sv
// Circular journal of uncommitted RAS ops: append at tail, retire at head, pop youngest at tail-1.
// Latency: updates visible the cycle after the strobe; count/youngest are registered-state decodes.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ras_ctrl_journal
    import ras_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld,
    input  jnl_entry_t       push_dat,
    input  logic             retire_vld,
    input  logic             pop_vld,
    output logic [CNT_W-1:0] count,
    output jnl_entry_t       youngest
);

    localparam int PTR_W = CNT_W - 1;

    jnl_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] yng_ptr;
    logic             do_retire;

    // Retiring an empty journal is a no-op so a stray commit cannot underflow the count.
    assign do_retire = retire_vld && (count != '0);
    assign yng_ptr   = tail - 1'b1;
    assign youngest  = mem[yng_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_vld)
                tail <= tail + 1'b1;
            else if (pop_vld)
                tail <= tail - 1'b1;
            if (do_retire)
                head <= head + 1'b1;
            count <= count + CNT_W'(push_vld) - CNT_W'(pop_vld) - CNT_W'(do_retire);
        end
    end

    always_ff @(posedge clock) begin
        if (push_vld)
            mem[tail] <= push_dat;
    end

endmodule

// File: rtl/ras_ctrl.sv
// RAS speculation controller: call/ret hints -> RAS push/pop strobes, journal-based unwind on flush.
// Latency: strobes in the accept cycle; coroutine push one cycle later; unwind one entry per cycle.
// Backpressure: pred_ready drops while busy or when fewer than two journal slots remain. Stats: RAS_CTRL_STAT_EN.
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int JDEPTH = 8,
    parameter int PC_INC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic              pred_is_call,
    input  logic              pred_is_ret,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_ready,
    output logic [ADDR_W-1:0] pred_target,
    output logic              pred_target_vld,
    input  logic              commit_valid,
    input  logic              flush,
    output logic              busy,
    output logic              jnl_full,
    output logic              ras_w_en,
    output logic              ras_r_en,
    output logic [ADDR_W-1:0] ras_waddr,
    input  logic [ADDR_W-1:0] ras_raddr
`ifdef RAS_CTRL_STAT_EN
    ,
    output logic [31:0]       stat_push,
    output logic [31:0]       stat_pop,
    output logic [31:0]       stat_unwind_cyc
`endif
);

    localparam int CNT_W = $clog2(JDEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] cor_addr;
    logic [ADDR_W-1:0] push_addr;
    logic [CNT_W-1:0]  jnl_cnt;
    logic [CNT_W-1:0]  cnt_after_commit;
    jnl_entry_t        jnl_yng;
    jnl_entry_t        jnl_push_dat;
    logic              jnl_push_vld;
    logic              jnl_pop_vld;
    logic              jnl_retire_vld;
    logic              accept;

    assign push_addr        = pred_pc + ADDR_W'(PC_INC);
    assign busy             = (state != IDLE);
    assign jnl_full         = (jnl_cnt > CNT_W'(JDEPTH - 2));
    assign pred_ready       = !busy && !jnl_full;
    assign pred_target      = ras_raddr;
    assign pred_target_vld  = pred_valid && pred_is_ret && pred_ready;
    // A flush discards whatever the predecoder offers in the same cycle.
    assign accept           = pred_valid && pred_ready && !flush;
    assign cnt_after_commit = jnl_cnt - CNT_W'(commit_valid && (jnl_cnt != '0));

    ras_ctrl_journal #(
        .DEPTH (JDEPTH),
        .CNT_W (CNT_W)
    ) u_journal (
        .clock      (clock),
        .reset      (reset),
        .push_vld   (jnl_push_vld),
        .push_dat   (jnl_push_dat),
        .retire_vld (jnl_retire_vld),
        .pop_vld    (jnl_pop_vld),
        .count      (jnl_cnt),
        .youngest   (jnl_yng)
    );

    always_comb begin
        ras_w_en       = 1'b0;
        ras_r_en       = 1'b0;
        ras_waddr      = '0;
        jnl_push_vld   = 1'b0;
        jnl_push_dat   = '0;
        jnl_pop_vld    = 1'b0;
        jnl_retire_vld = 1'b0;
        case (state)
            IDLE: begin
                jnl_retire_vld = commit_valid;
                if (accept && pred_is_ret) begin
                    // Plain ret, or first half of a coroutine swap.
                    ras_r_en     = 1'b1;
                    jnl_push_vld = 1'b1;
                    jnl_push_dat = '{op: JNL_POP, addr: ras_raddr};
                end else if (accept && pred_is_call) begin
                    ras_w_en     = 1'b1;
                    ras_waddr    = push_addr;
                    jnl_push_vld = 1'b1;
                    jnl_push_dat = '{op: JNL_PUSH, addr: push_addr};
                end
            end
            COROUT: begin
                jnl_retire_vld = commit_valid;
                if (!flush) begin
                    ras_w_en     = 1'b1;
                    ras_waddr    = cor_addr;
                    jnl_push_vld = 1'b1;
                    jnl_push_dat = '{op: JNL_PUSH, addr: cor_addr};
                end
            end
            UNWIND: begin
                jnl_pop_vld = 1'b1;
                if (jnl_yng.op == JNL_PUSH) begin
                    ras_r_en = 1'b1;
                end else begin
                    ras_w_en  = 1'b1;
                    ras_waddr = jnl_yng.addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cor_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= (cnt_after_commit != '0) ? UNWIND : IDLE;
                    end else if (accept && pred_is_call && pred_is_ret) begin
                        state    <= COROUT;
                        cor_addr <= push_addr;
                    end
                end
                COROUT: begin
                    if (flush)
                        state <= (cnt_after_commit != '0) ? UNWIND : IDLE;
                    else
                        state <= IDLE;
                end
                UNWIND: begin
                    if (jnl_cnt == CNT_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAS_CTRL_STAT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_push       <= '0;
            stat_pop        <= '0;
            stat_unwind_cyc <= '0;
        end else begin
            stat_push       <= sat_inc32(stat_push, ras_w_en);
            stat_pop        <= sat_inc32(stat_pop, ras_r_en);
            stat_unwind_cyc <= sat_inc32(stat_unwind_cyc, state == UNWIND);
        end
    end
`endif

endmodule
